// File: rtl/pipe_hazard_pkg.sv
// Shared types for the pipeline hazard controller: scoreboard slot, FSM state, register-address width.
// Latency: n/a (types and a pure helper function only).
// Backpressure: n/a.
package pipe_hazard_pkg;

   // Register-address width used by the scoreboard slot; pipe_hazard_ctrl's REG_AW must equal this.
   localparam int HZ_REG_AW = 5;

   // One in-flight writer as seen from ID: where it writes and whether it is a load.
   typedef struct packed {
      logic                 valid;
      logic [HZ_REG_AW-1:0] dest;
      logic                 reg_write;
      logic                 mem_read;
   } hz_slot_t;

   typedef enum logic [1:0] {
      RUN        = 2'd0,
      LOAD_STALL = 2'd1,
      RAW_STALL  = 2'd2,
      REDIRECT   = 2'd3
   } hz_state_e;

   // A slot produces a value a source needs only when it actually writes a
   // non-zero register; $0 is hard-wired, so writes to it never create a hazard.
   function automatic logic slot_hit(input hz_slot_t             s,
                                     input logic [HZ_REG_AW-1:0] rs,
                                     input logic [HZ_REG_AW-1:0] rt,
                                     input logic                 use_rs,
                                     input logic                 use_rt);
      logic live;
      live     = s.valid & s.reg_write & (s.dest != '0);
      slot_hit = live & ((use_rs & (s.dest == rs)) | (use_rt & (s.dest == rt)));
   endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Two-slot (EX, MEM) shift register of in-flight writers with per-slot source-match outputs.
// Latency: match outputs are combinational from the registered slots; slots update every clk edge.
// Backpressure: none; bubble/squash load an empty EX slot, MEM always takes the old EX slot.
//
// Ports:
//   clk, rst_n             clock, async active-low reset (clears both slots)
//   squash                 taken branch: the ID instruction is discarded, EX slot becomes empty
//   bubble                 stall: ID instruction is held, EX slot becomes empty
//   ins_*                  decoded writer info of the instruction leaving ID
//   src_rs/src_rt, use_*   source registers of the instruction currently in ID
//   ex_match/mem_match     slot holds a writer of one of the used sources
//   ex_match_load/mem_...  same, and that writer is a load
module hazard_scoreboard
   import pipe_hazard_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 squash,
   input  logic                 bubble,
   input  logic                 ins_valid,
   input  logic [HZ_REG_AW-1:0] ins_dest,
   input  logic                 ins_reg_write,
   input  logic                 ins_mem_read,
   input  logic [HZ_REG_AW-1:0] src_rs,
   input  logic [HZ_REG_AW-1:0] src_rt,
   input  logic                 use_rs,
   input  logic                 use_rt,
   output logic                 ex_match,
   output logic                 ex_match_load,
   output logic                 mem_match,
   output logic                 mem_match_load
);

   hz_slot_t ex_slot;
   hz_slot_t mem_slot;
   hz_slot_t ex_next;

   // Squash and bubble both inject an empty slot; they differ only in what
   // happens to IF/ID, which is the top's business.
   always_comb begin
      ex_next = '0;
      if (!(squash || bubble)) begin
         ex_next.valid     = ins_valid;
         ex_next.dest      = ins_dest;
         ex_next.reg_write = ins_reg_write;
         ex_next.mem_read  = ins_mem_read;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_slot  <= '0;
         mem_slot <= '0;
      end else begin
         ex_slot  <= ex_next;
         mem_slot <= ex_slot;
      end
   end

   assign ex_match       = slot_hit(ex_slot, src_rs, src_rt, use_rs, use_rt);
   assign mem_match      = slot_hit(mem_slot, src_rs, src_rt, use_rs, use_rt);
   assign ex_match_load  = ex_match & ex_slot.mem_read;
   assign mem_match_load = mem_match & mem_slot.mem_read;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Decides per cycle whether PC and IF/ID advance, stall or flush for a 5-stage MIPS pipeline.
// Latency: control outputs are combinational (same cycle); state/counters register one cycle later.
// Backpressure: a hazard holds PC and IF/ID and bubbles ID/EX; a taken branch overrides any stall.
//
// Build option: define HAZARD_FORWARD_EN when a forwarding unit is present; only a load in EX
// feeding the ID instruction then stalls (one cycle). Without it, any EX or MEM writer of a used
// source stalls (up to two cycles; WB is covered by the write-first register file).
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   id_*                ID-stage decode: valid, sources and use bits, RegDst-resolved dest,
//                       RegWrite, MemRead, Jump
//   ex_branch_taken     BEQ in EX resolved taken
//   pc_write            PC update enable
//   ifid_write          IF/ID enable
//   ifid_flush          load NOP into IF/ID
//   idex_bubble         zero control bits into ID/EX
//   state               registered classification of the previous cycle (debug only)
//   stall_cnt/flush_cnt saturating performance counters
module pipe_hazard_ctrl
   import pipe_hazard_pkg::*;
#(
   parameter int REG_AW = HZ_REG_AW,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic              id_use_rs,
   input  logic              id_use_rt,
   input  logic [REG_AW-1:0] id_dest,
   input  logic              id_reg_write,
   input  logic              id_mem_read,
   input  logic              id_jump,
   input  logic              ex_branch_taken,
   output logic              pc_write,
   output logic              ifid_write,
   output logic              ifid_flush,
   output logic              idex_bubble,
   output logic [1:0]        state,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
);

   logic      ex_match;
   logic      ex_match_load;
   logic      mem_match;
   logic      mem_match_load;
   logic      hit_any;
   logic      hit_load;
   logic      stall;
   logic      jump_flush;
   logic      flush_int;
   hz_state_e st;

   // A flushed ID instruction never enters EX, so it must not occupy a slot.
   hazard_scoreboard u_sb (
      .clk            (clk),
      .rst_n          (rst_n),
      .squash         (ex_branch_taken),
      .bubble         (stall),
      .ins_valid      (id_valid & ~flush_int),
      .ins_dest       (id_dest),
      .ins_reg_write  (id_reg_write),
      .ins_mem_read   (id_mem_read),
      .src_rs         (id_rs),
      .src_rt         (id_rt),
      .use_rs         (id_use_rs),
      .use_rt         (id_use_rt),
      .ex_match       (ex_match),
      .ex_match_load  (ex_match_load),
      .mem_match      (mem_match),
      .mem_match_load (mem_match_load)
   );

`ifdef HAZARD_FORWARD_EN
   // Forwarding covers everything except a load whose data is not back yet.
   logic unused_fwd;
   assign unused_fwd = ex_match ^ mem_match ^ mem_match_load;
   assign hit_any    = ex_match_load;
   assign hit_load   = ex_match_load;
`else
   assign hit_any  = ex_match | mem_match;
   assign hit_load = ex_match_load | mem_match_load;
`endif

   // The branch discards the ID instruction, so its hazard is moot.
   assign stall      = id_valid & hit_any & ~ex_branch_taken;
   assign jump_flush = id_valid & id_jump & ~hit_any & ~ex_branch_taken;
   assign flush_int  = ex_branch_taken | jump_flush;

   // Reset forces the free-running defaults regardless of the decode inputs.
   always_comb begin
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      if (rst_n) begin
         if (ex_branch_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
         end else if (stall) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
         end else if (jump_flush) begin
            ifid_flush  = 1'b1;
         end
      end
   end

   // State only records what was decided; it never feeds back into the outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st        <= RUN;
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (ex_branch_taken) begin
            st <= REDIRECT;
         end else if (stall && hit_load) begin
            st <= LOAD_STALL;
         end else if (stall) begin
            st <= RAW_STALL;
         end else begin
            st <= RUN;
         end
         if (stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
         end
         if (flush_int && (flush_cnt != '1)) begin
            flush_cnt <= flush_cnt + 1'b1;
         end
      end
   end

   assign state = st;

endmodule
